// File: rtl/lsu_pkg.sv
// Shared types and funct3 helpers for the load/store memory master.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Latched request fields still needed after the accept cycle.
  typedef struct packed {
    logic [2:0]  funct3;
    logic [63:0] wdata;
  } lsu_req_t;

  function automatic logic [3:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // D is always zero-extended, since there are no bits left to extend into.
  function automatic logic f3_signed(input logic [2:0] f3);
    return !f3[2] && (f3[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response handshake and 64-bit memory port of the load/store master.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;
  logic        memRead;
  logic        memWrite;
  logic [63:0] mem_address;
  logic [63:0] write_data;
  logic [63:0] read_data;

  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, read_data,
    output req_ready, resp_valid, resp_err, resp_rdata,
           memRead, memWrite, mem_address, write_data
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, read_data,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           memRead, memWrite, mem_address, write_data
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane extraction/extension for loads and sub-doubleword merge for stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] read_data,
  input  logic [63:0] wdata,
  input  logic [2:0]  funct3,
  output logic [63:0] load_val,
  output logic [63:0] merged
);

  logic sext;
  assign sext = f3_signed(funct3);

  always_comb begin
    load_val = read_data;
    merged   = wdata;
    case (f3_size(funct3))
      4'd1: begin
        load_val = {{56{sext & read_data[7]}}, read_data[7:0]};
        merged   = {read_data[63:8], wdata[7:0]};
      end
      4'd2: begin
        load_val = {{48{sext & read_data[15]}}, read_data[15:0]};
        merged   = {read_data[63:16], wdata[15:0]};
      end
      4'd4: begin
        load_val = {{32{sext & read_data[31]}}, read_data[31:0]};
        merged   = {read_data[63:32], wdata[31:0]};
      end
      default: begin
        load_val = read_data;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-request load/store master over an 8-byte memory port.
// Define LSU_MISALIGN_TRAP_EN to reject accesses not aligned to their size.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 64
) (
  input  logic              clk,
  input  logic              reset,
  lsu_mem_master_if.master  bus
);

  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  lsu_state_e  state;
  lsu_req_t    req_q;
  logic        resp_valid_q, resp_err_q;
  logic [63:0] resp_rdata_q;
  logic        mem_read_q, mem_write_q;
  logic [63:0] mem_address_q, write_data_q;
  logic [63:0] load_val, merged;
  logic        req_err;

  always_comb begin
    req_err = (bus.req_addr > MAX_ADDR) ||
              (!bus.req_store && bus.req_funct3 == 3'b111) ||
              (bus.req_store && bus.req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((bus.req_addr[2:0] & 3'(f3_size(bus.req_funct3) - 4'd1)) != 3'b000)
      req_err = 1'b1;
`endif
  end

  lsu_align u_align (
    .read_data (bus.read_data),
    .wdata     (req_q.wdata),
    .funct3    (req_q.funct3),
    .load_val  (load_val),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      req_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      write_data_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          req_q <= '{funct3: bus.req_funct3, wdata: bus.req_wdata};
          if (req_err) begin
            // Rejected requests leave the memory port untouched.
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            mem_address_q <= bus.req_addr;
            if (!bus.req_store) begin
              state      <= LOAD;
              mem_read_q <= 1'b1;
            end else if (bus.req_funct3 == F3_D) begin
              state        <= WRITE;
              mem_write_q  <= 1'b1;
              write_data_q <= bus.req_wdata;
            end else begin
              state      <= RMW_RD;
              mem_read_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          mem_read_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_val;
          state        <= RESP;
        end
        RMW_RD: begin
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b1;
          write_data_q <= merged;
          state        <= WRITE;
        end
        WRITE: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          state        <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.memRead     = mem_read_q;
  // A reset landing on the WRITE cycle must not commit the store.
  assign bus.memWrite    = mem_write_q & ~reset;
  assign bus.mem_address = mem_address_q;
  assign bus.write_data  = write_data_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Random and directed checks of lsu_mem_master against a byte-array reference model.
module tb_lsu_mem_master;
  localparam int MEM_BYTES = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_mem_master_if bus();

  lsu_mem_master #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Environment memory, reference copy, and port monitor.
  logic [7:0]  tb_mem  [MEM_BYTES];
  logic [7:0]  img     [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        ld_en;
  int          rd_cnt, wr_cnt;
  logic [63:0] last_wa, last_wd;
  int          n_checks = 0, n_errors = 0;

  always_comb begin
    logic [63:0] a;
    bus.read_data = '0;
    for (int i = 0; i < 8; i++) begin
      a = bus.mem_address + 64'(i);
      if (a < 64'(MEM_BYTES)) bus.read_data[8*i +: 8] = tb_mem[int'(a)];
    end
  end

  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < MEM_BYTES; i++) tb_mem[i] <= img[i];
      rd_cnt <= 0;
      wr_cnt <= 0;
    end else begin
      if (bus.memRead) rd_cnt <= rd_cnt + 1;
      if (bus.memWrite) begin
        wr_cnt  <= wr_cnt + 1;
        last_wa <= bus.mem_address;
        last_wd <= bus.write_data;
        for (int i = 0; i < 8; i++)
          if (bus.mem_address + 64'(i) < 64'(MEM_BYTES))
            tb_mem[int'(bus.mem_address) + i] <= bus.write_data[8*i +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3 % 4)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [63:0] addr);
    logic e;
    e = (addr > 64'(MEM_BYTES - 8)) || (!st && f3 == 3'd7) || (st && f3 >= 3'd4);
`ifdef LSU_MISALIGN_TRAP_EN
    if (size_of(f3) > 1 && (addr % 64'(size_of(f3))) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr);
    logic [63:0] v;
    int n;
    n = size_of(f3);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
    if (f3 <= 3'd2 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  // Issue one request, wait for its response and check it against the model.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, output logic [63:0] rdata);
    logic        e_err;
    int          e_lat, lat, rd0, wr0, n;
    logic [63:0] e_rdata, e_wd;
    bit          got_resp;
    e_err   = model_err(st, f3, addr);
    e_lat   = e_err ? 1 : ((!st || f3 == 3'd3) ? 2 : 3);
    e_rdata = (e_err || st) ? 64'd0 : model_load(f3, addr);
    e_wd    = 0;
    if (!e_err && st) begin
      n = size_of(f3);
      for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
      for (int i = 0; i < 8; i++) e_wd[8*i +: 8] = ref_mem[int'(addr) + i];
    end
    @(negedge clk);
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    got_resp = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.resp_valid) begin got_resp = 1; break; end
      @(posedge clk); #1;
      lat++;
    end
    if (!got_resp) begin
      chk("resp_timeout", 64'd0, 64'd1);
      rdata = 'x;
      return;
    end
    rdata = bus.resp_rdata;
    chk("latency", 64'(lat), 64'(e_lat));
    chk("resp_err", 64'(bus.resp_err), 64'(e_err));
    chk("resp_rdata", bus.resp_rdata, e_rdata);
    chk("rd_pulses", 64'(rd_cnt - rd0), (e_err || (st && f3 == 3'd3)) ? 64'd0 : 64'd1);
    chk("wr_pulses", 64'(wr_cnt - wr0), (!e_err && st) ? 64'd1 : 64'd0);
    if (!e_err && st) begin
      chk("wr_addr", last_wa, addr);
      chk("wr_data", last_wd, e_wd);
    end
    @(posedge clk); #1;
    chk("resp_one_cycle", 64'(bus.resp_valid), 64'd0);
  endtask

  logic [63:0] r;
  int          wr_before;

  initial begin
    bus.req_valid = 0; bus.req_store = 0; bus.req_funct3 = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      img[i]     = 8'($urandom);
      ref_mem[i] = img[i];
    end
    reset = 1; ld_en = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_memRead", 64'(bus.memRead), 64'd0);
    chk("rst_memWrite", 64'(bus.memWrite), 64'd0);
    chk("rst_mem_address", bus.mem_address, 64'd0);
    chk("rst_write_data", bus.write_data, 64'd0);
    reset = 0; ld_en = 0;

    // Directed sequence
    do_op(1, 3'd3, 64'd8, 64'h8877665544332211, r);
    chk("sd_wa", last_wa, 64'd8);
    chk("sd_wd", last_wd, 64'h8877665544332211);
    do_op(0, 3'd3, 64'd8, 0, r);  chk("ld8", r, 64'h8877665544332211);
    do_op(0, 3'd0, 64'd15, 0, r); chk("lb15", r, 64'hFFFFFFFFFFFFFF88);
    do_op(0, 3'd4, 64'd15, 0, r); chk("lbu15", r, 64'h88);
    do_op(0, 3'd1, 64'd14, 0, r); chk("lh14", r, 64'hFFFFFFFFFFFF8877);
    do_op(0, 3'd2, 64'd12, 0, r); chk("lw12", r, 64'hFFFFFFFF88776655);
    do_op(0, 3'd6, 64'd12, 0, r); chk("lwu12", r, 64'h0000000088776655);
    do_op(1, 3'd0, 64'd9, 64'hAB, r);
    chk("sb_wd", {8'h0, last_wd[55:0]}, 64'h00887766554433AB);
    do_op(0, 3'd3, 64'd8, 0, r);  chk("ld8_after_sb", r, 64'h887766554433AB11);
    do_op(0, 3'd3, 64'd57, 0, r); chk("err_ld57", r, 64'd0);
    do_op(0, 3'd0, 64'd60, 0, r); chk("err_lb60", r, 64'd0);
    do_op(0, 3'd7, 64'd0, 0, r);  chk("err_f3_7", r, 64'd0);
    do_op(1, 3'd4, 64'd0, 64'hFF, r);
    do_op(0, 3'd2, 64'd2, 0, r);

    // Reset landing on the WRITE cycle of SD 16
    @(negedge clk);
    bus.req_valid = 1; bus.req_store = 1; bus.req_funct3 = 3'd3;
    bus.req_addr = 64'd16; bus.req_wdata = 64'hDEADBEEFCAFEF00D;
    wr_before = wr_cnt;
    @(posedge clk); #1;
    bus.req_valid = 0;
    reset = 1;
    #1;
    chk("rstw_memWrite", 64'(bus.memWrite), 64'd0);
    @(posedge clk); #1;
    reset = 0;
    chk("rstw_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rstw_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rstw_no_write", 64'(wr_cnt - wr_before), 64'd0);
    @(posedge clk); #1;
    chk("rstw_resp_later", 64'(bus.resp_valid), 64'd0);
    do_op(0, 3'd3, 64'd16, 0, r);

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      logic [63:0] a;
      a = ($urandom_range(0, 9) == 0) ? 64'($urandom_range(57, 300)) : 64'($urandom_range(0, 56));
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
            {32'($urandom), 32'($urandom)}, r);
    end

    for (int i = 0; i < MEM_BYTES; i++) chk("final_mem", 64'(tb_mem[i]), 64'(ref_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
